// File: rtl/pc_sequencer_pkg.sv
// Shared types and default constants for the PC sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] DEF_FAULT_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry redirect buffer: a newer load overwrites, consume or flush clears the pending flag.
module pc_redirect_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Flush,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_LoadData,
    input  logic             i_Consume,
    output logic             o_Pend,
    output logic [WIDTH-1:0] o_Data
);

    logic             r_pend;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_pend <= 1'b0;
            r_data <= '0;
        end else if (i_Load) begin
            r_pend <= 1'b1;
            r_data <= i_LoadData;
        end else if (i_Flush || i_Consume) begin
            r_pend <= 1'b0;
        end
    end

    assign o_Pend = r_pend;
    assign o_Data = r_data;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: arbitrates halt, stall, redirect and sequential advance of the architectural PC.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect targets go to FAULT_VECTOR).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] FAULT_VECTOR = WIDTH'(DEF_FAULT_VECTOR)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_PCAddResult,
    input  logic             i_RedirectValid,
    input  logic [WIDTH-1:0] i_RedirectPC,
    input  logic             i_Stall,
    input  logic             i_Halt,
    input  logic             i_Resume,
    output logic [WIDTH-1:0] o_PCResult,
    output logic             o_PCValid,
    output logic             o_Halted,
    output logic             o_RedirectPend,
    output logic [31:0]      o_AdvanceCount,
    output logic             o_AlignFault
);

    seq_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_halted;
    logic [31:0]      r_count;
    logic             r_align_fault;

    logic             w_apply_redir;
    logic             w_apply_buf;
    logic             w_seq;
    logic             w_buf_load;
    logic             w_buf_pend;
    logic [WIDTH-1:0] w_buf_data;
    logic [WIDTH-1:0] w_target;
    logic             w_update;
    logic             w_misaligned;
    logic [WIDTH-1:0] w_pc_nxt;

    pc_redirect_buffer #(.WIDTH(WIDTH)) u_buf (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Flush    (w_apply_redir),
        .i_Load     (w_buf_load),
        .i_LoadData (i_RedirectPC),
        .i_Consume  (w_apply_buf),
        .o_Pend     (w_buf_pend),
        .o_Data     (w_buf_data)
    );

    // A PC not yet presented (first cycle out of reset) is held one cycle so it gets fetched.
    always_comb begin
        w_state_nxt   = r_state;
        w_apply_redir = 1'b0;
        w_apply_buf   = 1'b0;
        w_seq         = 1'b0;
        w_buf_load    = 1'b0;
        case (r_state)
            ST_HALTED: begin
                w_buf_load = i_RedirectValid;
                if (i_Resume && !i_Halt)
                    w_state_nxt = ST_RUN;
            end
            default: begin
                if (i_Halt) begin
                    w_state_nxt = ST_HALTED;
                    w_buf_load  = i_RedirectValid;
                end else if (i_Stall || !r_pc_valid) begin
                    w_state_nxt = i_Stall ? ST_STALL : ST_RUN;
                    w_buf_load  = i_RedirectValid;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (i_RedirectValid)
                        w_apply_redir = 1'b1;
                    else if (w_buf_pend)
                        w_apply_buf = 1'b1;
                    else
                        w_seq = 1'b1;
                end
            end
        endcase
    end

    assign w_target = w_apply_redir ? i_RedirectPC : w_buf_data;
    assign w_update = w_apply_redir | w_apply_buf | w_seq;

`ifdef PC_ALIGN_CHECK_EN
    assign w_misaligned = (w_apply_redir | w_apply_buf) && (w_target[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_pc_nxt = w_seq        ? i_PCAddResult :
                      w_misaligned ? FAULT_VECTOR  : w_target;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_halted      <= 1'b0;
            r_count       <= 32'd0;
            r_align_fault <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_valid    <= (w_state_nxt != ST_HALTED);
            r_halted      <= (w_state_nxt == ST_HALTED);
            r_align_fault <= w_misaligned;
            if (w_update) begin
                r_pc    <= w_pc_nxt;
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign o_PCResult     = r_pc;
    assign o_PCValid      = r_pc_valid;
    assign o_Halted       = r_halted;
    assign o_RedirectPend = w_buf_pend;
    assign o_AdvanceCount = r_count;
    assign o_AlignFault   = r_align_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle compare against a priority-rule model plus literal checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'd0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;
    logic [31:0] pc_add;

    logic [31:0] pc;
    logic        pc_valid, halted, pend, afault;
    logic [31:0] cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // incrementer, optionally overridden to prove the sequential PC is taken verbatim
    assign pc_add = ovr_en ? ovr_val : pc + 32'd4;

    pc_sequencer dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_PCAddResult   (pc_add),
        .i_RedirectValid (rv),
        .i_RedirectPC    (rpc),
        .i_Stall         (stall),
        .i_Halt          (halt),
        .i_Resume        (resume),
        .o_PCResult      (pc),
        .o_PCValid       (pc_valid),
        .o_Halted        (halted),
        .o_RedirectPend  (pend),
        .o_AdvanceCount  (cnt),
        .o_AlignFault    (afault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc = 32'd0, m_buf = 32'd0, m_cnt = 32'd0;
    bit m_presented = 0, m_halted = 0, m_pend = 0, m_fault = 0;

    function automatic logic [31:0] land(input logic [31:0] t, output bit f);
        f = 0;
`ifdef PC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
            f = 1;
            return 32'h80;
        end
`endif
        return t;
    endfunction

    always @(posedge clk) begin
        logic [31:0] add;
        bit f;
        add = ovr_en ? ovr_val : m_pc + 32'd4;
        f = 0;
        if (rst) begin
            m_pc = 32'd0; m_presented = 0; m_halted = 0;
            m_pend = 0; m_cnt = 32'd0; m_fault = 0;
        end else begin
            if (m_halted) begin
                if (rv) begin m_buf = rpc; m_pend = 1; end
                if (resume && !halt) begin m_halted = 0; m_presented = 1; end
            end else if (halt) begin
                if (rv) begin m_buf = rpc; m_pend = 1; end
                m_halted = 1; m_presented = 0;
            end else if (stall || !m_presented) begin
                if (rv) begin m_buf = rpc; m_pend = 1; end
                m_presented = 1;
            end else if (rv) begin
                m_pc = land(rpc, f); m_pend = 0; m_cnt++;
            end else if (m_pend) begin
                m_pc = land(m_buf, f); m_pend = 0; m_cnt++;
            end else begin
                m_pc = add; m_cnt++;
            end
            m_fault = f;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.pc", pc, m_pc);
            chk("model.valid", {31'd0, pc_valid}, {31'd0, m_presented && !m_halted});
            chk("model.halted", {31'd0, halted}, {31'd0, m_halted});
            chk("model.pend", {31'd0, pend}, {31'd0, m_pend});
            chk("model.count", cnt, m_cnt);
            chk("model.fault", {31'd0, afault}, {31'd0, m_fault});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("rst.pc", pc, 32'h0);
        chk("rst.valid", {31'd0, pc_valid}, 32'd0);
        chk("rst.count", cnt, 32'd0);
        chk("rst.pend", {31'd0, pend}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);

        // 1: free run
        rst = 1'b0;
        tick(1);
        chk("t1.valid_rise", {31'd0, pc_valid}, 32'd1);
        chk("t1.pc0", pc, 32'h0);
        tick(4);
        chk("t1.pc10", pc, 32'h10);
        chk("t1.count4", cnt, 32'd4);

        // 2: redirect at PC=8
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(3);
        chk("t2.pc8", pc, 32'h8);
        rv = 1'b1; rpc = 32'h40; tick(1); rv = 1'b0;
        chk("t2.pc40", pc, 32'h40);
        tick(1);
        chk("t2.pc44", pc, 32'h44);
        chk("t2.count", cnt, 32'd4);

        // 3: stall with two redirects, newest wins on release
        stall = 1'b1; rv = 1'b1; rpc = 32'h100; tick(1);
        rpc = 32'h200; tick(1);
        rv = 1'b0; tick(1);
        chk("t3.held", pc, 32'h44);
        chk("t3.pend", {31'd0, pend}, 32'd1);
        chk("t3.valid", {31'd0, pc_valid}, 32'd1);
        stall = 1'b0; tick(1);
        chk("t3.pc200", pc, 32'h200);
        chk("t3.pend_clr", {31'd0, pend}, 32'd0);

        // 4: live redirect beats buffered one on release
        stall = 1'b1; rv = 1'b1; rpc = 32'h200; tick(1);
        rv = 1'b0; tick(1);
        chk("t4.pend", {31'd0, pend}, 32'd1);
        stall = 1'b0; rv = 1'b1; rpc = 32'h300; tick(1); rv = 1'b0;
        chk("t4.pc300", pc, 32'h300);
        chk("t4.pend_clr", {31'd0, pend}, 32'd0);
        tick(1);
        chk("t4.pc304", pc, 32'h304);

        // 5: halt, redirect while halted, resume
        rv = 1'b1; rpc = 32'h20; tick(1); rv = 1'b0;
        halt = 1'b1; tick(1);
        chk("t5.halted", {31'd0, halted}, 32'd1);
        chk("t5.invalid", {31'd0, pc_valid}, 32'd0);
        chk("t5.pc20", pc, 32'h20);
        rv = 1'b1; rpc = 32'h80; tick(1); rv = 1'b0; tick(1);
        chk("t5.pend", {31'd0, pend}, 32'd1);
        chk("t5.still_invalid", {31'd0, pc_valid}, 32'd0);
        halt = 1'b0; resume = 1'b1; tick(1); resume = 1'b0;
        chk("t5.resumed", {31'd0, halted}, 32'd0);
        chk("t5.pc_hold", pc, 32'h20);
        tick(1);
        chk("t5.pc80", pc, 32'h80);
        // Resume while Halt still high keeps HALTED
        halt = 1'b1; tick(1);
        resume = 1'b1; tick(1); resume = 1'b0;
        chk("t5.resume_halt", {31'd0, halted}, 32'd1);
        halt = 1'b0; resume = 1'b1; tick(1); resume = 1'b0; tick(1);
        chk("t5.pc84", pc, 32'h84);

        // 6: reset mid-stall drops pending redirect
        stall = 1'b1; rv = 1'b1; rpc = 32'h500; tick(1); rv = 1'b0; tick(1);
        chk("t6.pend", {31'd0, pend}, 32'd1);
        rst = 1'b1; tick(1);
        chk("t6.pc", pc, 32'h0);
        chk("t6.pend_clr", {31'd0, pend}, 32'd0);
        chk("t6.count", cnt, 32'd0);
        stall = 1'b0; rst = 1'b0; tick(2);
        chk("t6.pc4", pc, 32'h4);

        // PC wrap through the incrementer
        rv = 1'b1; rpc = 32'hFFFF_FFFC; tick(1); rv = 1'b0;
        chk("wrap.top", pc, 32'hFFFF_FFFC);
        tick(1);
        chk("wrap.zero", pc, 32'h0);

        // sequential PC is PCAddResult verbatim
        ovr_en = 1'b1; ovr_val = 32'h1234; tick(1); ovr_en = 1'b0;
        chk("verbatim", pc, 32'h1234);

        // Halt outranks a same-cycle redirect, which is buffered
        halt = 1'b1; rv = 1'b1; rpc = 32'h600; tick(1); rv = 1'b0; halt = 1'b0;
        chk("hprio.pc", pc, 32'h1234);
        chk("hprio.pend", {31'd0, pend}, 32'd1);
        resume = 1'b1; tick(1); resume = 1'b0; tick(1);
        chk("hprio.pc600", pc, 32'h600);

        // misaligned redirect
        rv = 1'b1; rpc = 32'h42; tick(1); rv = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("align.pc", pc, 32'h80);
        chk("align.fault", {31'd0, afault}, 32'd1);
        tick(1);
        chk("align.fault_clr", {31'd0, afault}, 32'd0);
        chk("align.pc84", pc, 32'h84);
`else
        chk("align.pc", pc, 32'h42);
        chk("align.fault", {31'd0, afault}, 32'd0);
        tick(1);
        chk("align.pc46", pc, 32'h46);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
